tt_mask_idx_elem_seq: RTL and testbench
=======================================

// Module: tt_mask_idx_elem_seq
// PURPOSE
//  Receive-side sequencer for the 65-bit mask/index channel {mask bit[64], data[63:0]} fed by the VPU mask FSM.
//  Buffers items in a MASK_CREDITS-deep FIFO and returns one credit per popped item.
//  Expands the buffered items into one element per cycle for the memory request generator:
//  strided = 64 mask bits per item, indexed = one {mask, index} per item.
//  Unmasked strided memops are sequenced without consuming any items.
// PARAMETERS
//  VLEN          256  vector length in bits; bounds vl to 0..VLEN
//  MASK_CREDITS  2    FIFO depth; must equal the producer's initial credit count
// PORTS
//  i_clk                in   1               clock
//  i_reset_n            in   1               async active-low reset
//  i_start              in   1               memop start pulse; samples i_vl, i_is_indexed, i_is_masked
//  i_vl                 in   $clog2(VLEN+1)  element count
//  i_is_indexed         in   1               indexed memop
//  i_is_masked          in   1               masked memop (strided only; indexed always consumes items)
//  i_mask_idx_valid     in   1               item push
//  i_mask_idx_item      in   65              {mask, data[63:0]}
//  i_mask_idx_last_idx  in   1               producer's last-item marker
//  i_elem_ready         in   1               consumer accepts element
//  o_mask_idx_credit    out  1               credit return pulse, one per popped item
//  o_elem_valid         out  1               element valid
//  o_elem_active        out  1               element mask bit (1 = perform access)
//  o_elem_index         out  64              indexed: offset from item; strided: element number, zero-extended
//  o_elem_last          out  1               element vl-1
//  o_busy               out  1               state != IDLE
//  o_err                out  1               sticky: overflow or last_idx mismatch
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, element counter 0.
//   Async assert clears everything, including mid-operation. No credits are returned for flushed items.
//  States:
//   IDLE: i_start && i_vl!=0 -> RUN; latch vl, mode, masked; elem_cnt=0; bit_ptr=0.
//     i_start with vl=0 is ignored. i_start outside IDLE is ignored.
//   RUN: after the element with elem_cnt==vl-1 is accepted -> IDLE, same edge.
//  Element presentation:
//   o_elem_valid=1 in RUN when the element's source is available:
//    unmasked strided: always available;
//    otherwise: FIFO non-empty.
//   Outputs are combinational from the FIFO head, bit_ptr and elem_cnt. Valid/data hold stable until i_elem_ready.
//   Accept = o_elem_valid && i_elem_ready; each accept increments elem_cnt.
//   o_elem_last = (elem_cnt == vl-1).
//  Strided masked: o_elem_active = head.data[bit_ptr]; o_elem_index = elem_cnt.
//   bit_ptr (6b) increments per accept.
//   Head is popped when bit_ptr==63 or on the last element. bit_ptr resets to 0 on pop.
//  Strided unmasked: o_elem_active=1; o_elem_index=elem_cnt; no pops.
//  Indexed: o_elem_active=head.mask; o_elem_index=head.data; pop on every accept.
//  FIFO:
//   Push when i_mask_idx_valid, in any state; items may arrive before i_start.
//   Push and pop in the same cycle is legal at full and at empty (pass-through not required).
//   Push while full and no pop -> item dropped, o_err set.
//   Count width is $clog2(MASK_CREDITS+1). Pointers wrap modulo MASK_CREDITS.
//  Credit: o_mask_idx_credit is registered and pulses 1 cycle after each pop. Back-to-back pops give back-to-back pulses.
//  last_idx check: if a popped item's stored last_idx flag != (this pop is the final pop of the memop), set o_err.
//  o_err clears only on reset.
// TESTING
//  Reset, then i_start vl=5 indexed; push 5 items idx=0x10..0x14, mask=1,0,1,1,0, last_idx on item 5
//   -> 5 elements with index 0x10..0x14, active 1,0,1,1,0; last on elem 4; 5 credit pulses; o_busy falls.
//  Strided masked vl=130; push 0xAAAA..AA, 0x5555..55, 0x3
//   -> 130 elements, active alternates, elems 128/129 active=1, 3 pops, last on index 129.
//  Strided unmasked vl=200 with i_elem_ready toggled every cycle
//   -> 200 elements, all active, no credits, outputs stable while not ready.
//  Push 3 items with MASK_CREDITS=2 and no consumer -> third item dropped, o_err=1, count stays 2.
//  Assert i_reset_n low at element 3 of 5 -> all outputs 0 asynchronously; next i_start vl=1 runs cleanly.
//  i_start with vl=0, then i_start during RUN -> both ignored; in-flight memop completes unchanged.

Source files
------------

// File: rtl/tt_mask_idx_elem_seq.sv
// Receive-side mask/index sequencer: buffers {mask, data} items from the VPU
// mask FSM, returns a credit per popped item, and expands the items into one
// element per cycle for the memory request generator.
module tt_mask_idx_elem_seq #(
    parameter int unsigned VLEN         = 256,
    parameter int unsigned MASK_CREDITS = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_start,
    input  logic [$clog2(VLEN+1)-1:0]     i_vl,
    input  logic                          i_is_indexed,
    input  logic                          i_is_masked,
    input  logic                          i_mask_idx_valid,
    input  logic [64:0]                   i_mask_idx_item,
    input  logic                          i_mask_idx_last_idx,
    input  logic                          i_elem_ready,
    output logic                          o_mask_idx_credit,
    output logic                          o_elem_valid,
    output logic                          o_elem_active,
    output logic [63:0]                   o_elem_index,
    output logic                          o_elem_last,
    output logic                          o_busy,
    output logic                          o_err
);

    localparam int unsigned VL_W  = $clog2(VLEN + 1);
    localparam int unsigned CNT_W = $clog2(MASK_CREDITS + 1);
    localparam int unsigned PTR_W = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
    localparam int unsigned BIT_W = 6;

    typedef struct packed {
        logic        mask;
        logic [63:0] data;
        logic        last_idx;
    } entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    entry_t             fifo_q [MASK_CREDITS];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VL_W-1:0]    vl_q, vl_d;
    logic [VL_W-1:0]    elem_cnt_q, elem_cnt_d;
    logic [BIT_W-1:0]   bit_ptr_q, bit_ptr_d;
    logic               idx_q, idx_d;
    logic               masked_q, masked_d;
    logic               credit_q, credit_d;
    logic               err_q, err_d;

    entry_t             head;
    entry_t             push_entry;
    logic [VL_W-1:0]    vl_in;
    logic               fifo_empty, fifo_full;
    logic               unmasked_strided;
    logic               elem_valid, accept, elem_last;
    logic               pop, push, overflow, last_err;
    logic               start_go;

    // Next pointer with wrap at the FIFO depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MASK_CREDITS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Element presentation, FIFO handshake and error detection.
    always_comb begin
        head             = fifo_q[rd_ptr_q];
        push_entry       = '{mask: i_mask_idx_item[64], data: i_mask_idx_item[63:0],
                             last_idx: i_mask_idx_last_idx};
        vl_in            = (i_vl > VL_W'(VLEN)) ? VL_W'(VLEN) : i_vl;
        fifo_empty       = (cnt_q == '0);
        fifo_full        = (cnt_q == CNT_W'(MASK_CREDITS));
        unmasked_strided = !idx_q && !masked_q;
        elem_valid       = (state_q == ST_RUN) && (unmasked_strided || !fifo_empty);
        accept           = elem_valid && i_elem_ready;
        elem_last        = (elem_cnt_q == (vl_q - VL_W'(1)));
        pop              = accept && !unmasked_strided &&
                           (idx_q || (bit_ptr_q == BIT_W'(63)) || elem_last);
        push             = i_mask_idx_valid && (!fifo_full || pop);
        overflow         = i_mask_idx_valid && fifo_full && !pop;
        last_err         = pop && (head.last_idx != elem_last);
        start_go         = (state_q == ST_IDLE) && i_start && (i_vl != '0);

        o_elem_valid     = elem_valid;
        o_elem_active    = 1'b0;
        o_elem_index     = '0;
        o_elem_last      = elem_valid && elem_last;
        if (elem_valid) begin
            if (idx_q) begin
                o_elem_active = head.mask;
                o_elem_index  = head.data;
            end else begin
                o_elem_active = unmasked_strided ? 1'b1 : head.data[bit_ptr_q];
                o_elem_index  = 64'(elem_cnt_q);
            end
        end
    end

    // FSM next state: a memop runs until its final element is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_go) state_d = ST_RUN;
            ST_RUN:  if (accept && elem_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next state: memop latches, counters, FIFO pointers, credit and error.
    always_comb begin
        vl_d       = vl_q;
        idx_d      = idx_q;
        masked_d   = masked_q;
        elem_cnt_d = elem_cnt_q;
        bit_ptr_d  = bit_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        credit_d   = pop;
        err_d      = err_q || overflow || last_err;

        if (start_go) begin
            vl_d       = vl_in;
            idx_d      = i_is_indexed;
            masked_d   = i_is_masked;
            elem_cnt_d = '0;
            bit_ptr_d  = '0;
        end else if (accept) begin
            elem_cnt_d = elem_cnt_q + VL_W'(1);
            bit_ptr_d  = pop ? '0 : bit_ptr_q + BIT_W'(1);
        end

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    // State and control registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            vl_q       <= '0;
            idx_q      <= 1'b0;
            masked_q   <= 1'b0;
            elem_cnt_q <= '0;
            bit_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            credit_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vl_q       <= vl_d;
            idx_q      <= idx_d;
            masked_q   <= masked_d;
            elem_cnt_q <= elem_cnt_d;
            bit_ptr_q  <= bit_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; reset flushes it without returning credits.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(MASK_CREDITS); i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign o_mask_idx_credit = credit_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign o_err             = err_q;

endmodule

// File: tb/tb_tt_mask_idx_elem_seq.sv
// Self-checking bench for tt_mask_idx_elem_seq: table of memops plus random
// memops against an element-list model, and directed reset/overflow/ignore cases.
module tb_tt_mask_idx_elem_seq;

    localparam int unsigned VLEN = 256;
    localparam int unsigned VW   = $clog2(VLEN + 1);
    localparam int          BUDGET = 3000;

    logic          clk, rst_n;
    logic          i_start, i_is_indexed, i_is_masked;
    logic [VW-1:0] i_vl;
    logic          i_mask_idx_valid, i_mask_idx_last_idx, i_elem_ready;
    logic [64:0]   i_mask_idx_item;
    logic          o_mask_idx_credit, o_elem_valid, o_elem_active, o_elem_last;
    logic [63:0]   o_elem_index;
    logic          o_busy, o_err;

    tt_mask_idx_elem_seq #(.VLEN(VLEN), .MASK_CREDITS(2)) dut (
        .i_clk               (clk),
        .i_reset_n           (rst_n),
        .i_start             (i_start),
        .i_vl                (i_vl),
        .i_is_indexed        (i_is_indexed),
        .i_is_masked         (i_is_masked),
        .i_mask_idx_valid    (i_mask_idx_valid),
        .i_mask_idx_item     (i_mask_idx_item),
        .i_mask_idx_last_idx (i_mask_idx_last_idx),
        .i_elem_ready        (i_elem_ready),
        .o_mask_idx_credit   (o_mask_idx_credit),
        .o_elem_valid        (o_elem_valid),
        .o_elem_active       (o_elem_active),
        .o_elem_index        (o_elem_index),
        .o_elem_last         (o_elem_last),
        .o_busy              (o_busy),
        .o_err               (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        active;
        logic [63:0] index;
        logic        last;
    } elem_t;

    typedef struct {
        int vl;
        bit ix;
        bit mk;
        int pat;       // 0 random items, 1 indexed 0x10.. pattern, 2 AAAA/5555/3 pattern
        int rmode;     // 0 always ready, 1 toggling ready, 2 random ready
        int exp_cred;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          tb_credits;
    logic [64:0] items[$];
    elem_t       expq[$];
    vec_t        tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        tb_credits = 2;
    endtask

    // Runs one memop end to end: model builds the element list from the items,
    // producer pushes under credit flow control, consumer checks every element.
    task automatic run_op(input int vl, input bit ix, input bit mk, input int pat,
                          input int rmode, input int exp_cred, input bit inj, input string nm);
        int          n_items, pushed, k, ncred, cyc, drain;
        bit          tog;
        logic [63:0] w;
        logic [63:0] pat_idx_mask;
        items.delete();
        expq.delete();
        pat_idx_mask = 64'b01101;
        n_items = ix ? vl : (mk ? (vl + 63) / 64 : 0);
        for (int i = 0; i < n_items; i++) begin
            case (pat)
                1:       items.push_back({pat_idx_mask[i % 5], 64'(64'h10 + i)});
                2:       items.push_back({1'b0, (i == 0) ? 64'hAAAA_AAAA_AAAA_AAAA :
                                                (i == 1) ? 64'h5555_5555_5555_5555 : 64'h3});
                default: items.push_back({1'($urandom), $urandom, $urandom});
            endcase
        end
        for (int e = 0; e < vl; e++) begin
            elem_t x;
            if (ix) begin
                x.active = items[e][64];
                x.index  = items[e][63:0];
            end else if (mk) begin
                w        = items[e / 64][63:0];
                x.active = w[e % 64];
                x.index  = 64'(e);
            end else begin
                x.active = 1'b1;
                x.index  = 64'(e);
            end
            x.last = (e == vl - 1);
            expq.push_back(x);
        end

        i_start = 1'b1; i_vl = VW'(vl); i_is_indexed = ix; i_is_masked = mk;
        step();
        i_start = 1'b0;
        pushed = 0; k = 0; ncred = 0; cyc = 0; drain = 0; tog = 1'b0;
        while (drain < 4 && cyc < BUDGET) begin
            if (inj && cyc == 2) begin
                i_start = 1'b1; i_vl = VW'(9); i_is_indexed = 1'b1; i_is_masked = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            if (pushed < n_items && tb_credits > 0) begin
                i_mask_idx_valid    = 1'b1;
                i_mask_idx_item     = items[pushed];
                i_mask_idx_last_idx = (pushed == n_items - 1);
                tb_credits--;
                pushed++;
            end else begin
                i_mask_idx_valid    = 1'b0;
                i_mask_idx_last_idx = 1'b0;
            end
            case (rmode)
                0:       i_elem_ready = 1'b1;
                1:       begin i_elem_ready = tog; tog = !tog; end
                default: i_elem_ready = 1'($urandom_range(0, 1));
            endcase
            #3;
            if (o_mask_idx_credit) begin
                tb_credits++;
                ncred++;
            end
            if (o_elem_valid) begin
                if (k >= vl) begin
                    chk({nm, "_extra_elem"}, 64'(o_elem_valid), 64'd0);
                end else begin
                    chk({nm, "_active"}, 64'(o_elem_active), 64'(expq[k].active));
                    chk({nm, "_index"},  o_elem_index,       expq[k].index);
                    chk({nm, "_last"},   64'(o_elem_last),   64'(expq[k].last));
                    if (i_elem_ready) k++;
                end
            end
            if (k >= vl) drain++;
            step();
            cyc++;
        end
        i_start = 1'b0; i_mask_idx_valid = 1'b0; i_elem_ready = 1'b0;
        #3;
        chk({nm, "_no_timeout"}, 64'(cyc < BUDGET), 64'd1);
        chk({nm, "_elem_count"}, 64'(k),            64'(vl));
        chk({nm, "_credits"},    64'(ncred),        64'(exp_cred));
        chk({nm, "_busy_end"},   64'(o_busy),       64'd0);
        chk({nm, "_err_end"},    64'(o_err),        64'd0);
        step();
    endtask

    initial begin
        tbl[0] = '{vl: 5,   ix: 1'b1, mk: 1'b0, pat: 1, rmode: 0, exp_cred: 5};
        tbl[1] = '{vl: 130, ix: 1'b0, mk: 1'b1, pat: 2, rmode: 2, exp_cred: 3};
        tbl[2] = '{vl: 200, ix: 1'b0, mk: 1'b0, pat: 0, rmode: 1, exp_cred: 0};
        tbl[3] = '{vl: 64,  ix: 1'b0, mk: 1'b1, pat: 0, rmode: 2, exp_cred: 1};
        tbl[4] = '{vl: 65,  ix: 1'b0, mk: 1'b1, pat: 0, rmode: 0, exp_cred: 2};
        tbl[5] = '{vl: 1,   ix: 1'b1, mk: 1'b0, pat: 0, rmode: 2, exp_cred: 1};
        tbl[6] = '{vl: 256, ix: 1'b0, mk: 1'b1, pat: 0, rmode: 2, exp_cred: 4};
        tbl[7] = '{vl: 1,   ix: 1'b0, mk: 1'b1, pat: 0, rmode: 1, exp_cred: 1};
        tbl[8] = '{vl: 7,   ix: 1'b1, mk: 1'b0, pat: 0, rmode: 2, exp_cred: 7};
        tbl[9] = '{vl: 256, ix: 1'b0, mk: 1'b0, pat: 0, rmode: 2, exp_cred: 0};

        i_start = 1'b0; i_vl = '0; i_is_indexed = 1'b0; i_is_masked = 1'b0;
        i_mask_idx_valid = 1'b0; i_mask_idx_item = '0; i_mask_idx_last_idx = 1'b0;
        i_elem_ready = 1'b0;
        do_reset();
        #3;
        chk("rst_valid",  64'(o_elem_valid),      64'd0);
        chk("rst_active", 64'(o_elem_active),     64'd0);
        chk("rst_index",  o_elem_index,           64'd0);
        chk("rst_last",   64'(o_elem_last),       64'd0);
        chk("rst_credit", 64'(o_mask_idx_credit), 64'd0);
        chk("rst_busy",   64'(o_busy),            64'd0);
        chk("rst_err",    64'(o_err),             64'd0);
        step();

        for (int t = 0; t < 10; t++)
            run_op(tbl[t].vl, tbl[t].ix, tbl[t].mk, tbl[t].pat, tbl[t].rmode,
                   tbl[t].exp_cred, 1'b0, $sformatf("tbl%0d", t));

        for (int r = 0; r < 8; r++) begin
            int vl;
            bit ix, mk;
            vl = $urandom_range(1, 256);
            ix = 1'($urandom_range(0, 1));
            mk = 1'($urandom_range(0, 1));
            run_op(vl, ix, mk, 0, 2, ix ? vl : (mk ? (vl + 63) / 64 : 0), 1'b0,
                   $sformatf("rnd%0d", r));
        end

        // vl=0 start is ignored; a start during RUN does not disturb the memop.
        i_start = 1'b1; i_vl = '0; i_is_indexed = 1'b0; i_is_masked = 1'b0;
        step();
        i_start = 1'b0;
        #3;
        chk("vl0_busy",  64'(o_busy),       64'd0);
        chk("vl0_valid", 64'(o_elem_valid), 64'd0);
        step();
        run_op(4, 1'b0, 1'b0, 0, 0, 0, 1'b1, "restart_ignored");

        // Overflow: third push with no consumer is dropped and flags the error.
        i_mask_idx_valid = 1'b1; i_mask_idx_item = {1'b1, 64'hA0}; i_mask_idx_last_idx = 1'b0;
        step();
        i_mask_idx_item = {1'b0, 64'hB0}; i_mask_idx_last_idx = 1'b1;
        step();
        i_mask_idx_item = {1'b1, 64'hC0}; i_mask_idx_last_idx = 1'b0;
        #3;
        chk("ovf_err_before", 64'(o_err), 64'd0);
        step();
        i_mask_idx_valid = 1'b0;
        #3;
        chk("ovf_err_set", 64'(o_err), 64'd1);
        step();
        i_start = 1'b1; i_vl = VW'(2); i_is_indexed = 1'b1; i_is_masked = 1'b0;
        step();
        i_start = 1'b0; i_elem_ready = 1'b1;
        #3;
        chk("ovf_e0_valid",  64'(o_elem_valid),  64'd1);
        chk("ovf_e0_index",  o_elem_index,       64'hA0);
        chk("ovf_e0_active", 64'(o_elem_active), 64'd1);
        chk("ovf_e0_last",   64'(o_elem_last),   64'd0);
        step();
        #3;
        chk("ovf_e1_index",  o_elem_index,           64'hB0);
        chk("ovf_e1_active", 64'(o_elem_active),     64'd0);
        chk("ovf_e1_last",   64'(o_elem_last),       64'd1);
        chk("ovf_credit0",   64'(o_mask_idx_credit), 64'd1);
        step();
        #3;
        chk("ovf_busy_end", 64'(o_busy),            64'd0);
        chk("ovf_credit1",  64'(o_mask_idx_credit), 64'd1);
        step();
        i_start = 1'b1; i_vl = VW'(1); i_is_indexed = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk("ovf_dropped_no_elem", 64'(o_elem_valid), 64'd0);
            step();
        end
        #3;
        chk("ovf_busy_waiting", 64'(o_busy), 64'd1);
        chk("ovf_err_sticky",   64'(o_err),  64'd1);
        step();
        i_elem_ready = 1'b0;
        do_reset();
        #3;
        chk("ovf_err_cleared", 64'(o_err),  64'd0);
        chk("ovf_busy_reset",  64'(o_busy), 64'd0);
        step();

        // Async reset in the middle of a memop clears all outputs immediately.
        i_start = 1'b1; i_vl = VW'(5); i_is_indexed = 1'b0; i_is_masked = 1'b0;
        step();
        i_start = 1'b0; i_elem_ready = 1'b1;
        step(); step(); step();
        #3;
        chk("arst_pre_index", o_elem_index, 64'd3);
        chk("arst_pre_busy",  64'(o_busy),  64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  64'(o_elem_valid),      64'd0);
        chk("arst_active", 64'(o_elem_active),     64'd0);
        chk("arst_index",  o_elem_index,           64'd0);
        chk("arst_last",   64'(o_elem_last),       64'd0);
        chk("arst_credit", 64'(o_mask_idx_credit), 64'd0);
        chk("arst_busy",   64'(o_busy),            64'd0);
        chk("arst_err",    64'(o_err),             64'd0);
        i_elem_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        tb_credits = 2;
        step();
        run_op(1, 1'b0, 1'b0, 0, 0, 0, 1'b0, "post_arst");
        run_op(3, 1'b1, 1'b0, 0, 2, 3, 1'b0, "post_arst_idx");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
